// File: rtl/botao_pkg.sv
// Shared constants and types for the push-button debounce controller.
package botao_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_DBLIMIT = ADDR_W'(3);

  localparam int unsigned CAPTURE_PRESS   = 0;
  localparam int unsigned CAPTURE_RELEASE = 1;
  localparam int unsigned CAPTURE_BOTH    = 2;

  typedef enum logic [1:0] {
    STABLE_IDLE,
    WAIT_ACTIVE,
    STABLE_ACTIVE,
    WAIT_IDLE
  } db_state_t;

endpackage

// File: rtl/botao_debounce.sv
// Two-flop synchronizer plus stable-interval debounce FSM for one button pin.
module botao_debounce
  import botao_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pin,
  input  logic [CNT_W-1:0] limit,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim_m1_c;
  db_state_t        state;

  // A zero limit behaves as one cycle; compare against limit-1.
  assign lim_m1_c = (limit == '0) ? '0 : limit - CNT_W'(1);

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: accept a new level only after it holds for the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STABLE_IDLE;
      cnt   <= '0;
      level <= IDLE_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_IDLE, STABLE_ACTIVE: begin
          if (sync2 != level) begin
            state <= (state == STABLE_IDLE) ? WAIT_ACTIVE : WAIT_IDLE;
            cnt   <= '0;
          end
        end
        WAIT_ACTIVE, WAIT_IDLE: begin
          if (sync2 == level) begin
            state <= (state == WAIT_ACTIVE) ? STABLE_IDLE : STABLE_ACTIVE;
            cnt   <= '0;
          end else if (cnt >= lim_m1_c) begin
            state <= (state == WAIT_ACTIVE) ? STABLE_ACTIVE : STABLE_IDLE;
            cnt   <= '0;
            level <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/botao_debounce_ctrl.sv
// Avalon-MM push-button controller: debounced level, sticky edge capture, maskable irq.
module botao_debounce_ctrl
  import botao_pkg::*;
#(
  parameter int unsigned DB_RESET     = 50000,
  parameter int unsigned IDLE_LEVEL   = 1,
  parameter int unsigned CAPTURE_EDGE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  input  logic              in_port,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  localparam logic IDLE_BIT = 1'(IDLE_LEVEL);

  logic             level;
  logic             rise;
  logic             fall;
  logic             irq_mask;
  logic             edgecap;
  logic [CNT_W-1:0] dblimit;
  logic             wr_en_c;
  logic             edge_c;
  logic             unused_ok;

  assign wr_en_c   = chipselect & ~write_n;
  assign unused_ok = &{1'b0, writedata[DATA_W-1:CNT_W]};

  botao_debounce #(
    .IDLE_LEVEL(IDLE_BIT)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .pin    (in_port),
    .limit  (dblimit),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // Map rise/fall onto press/release and pick the configured edge(s).
  always_comb begin
    edge_c = 1'b0;
    case (CAPTURE_EDGE)
      CAPTURE_PRESS:   edge_c = IDLE_BIT ? fall : rise;
      CAPTURE_RELEASE: edge_c = IDLE_BIT ? rise : fall;
      default:         edge_c = rise | fall;
    endcase
  end

  // Control registers; an edge in the same cycle as a W1C clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= 1'b0;
      edgecap  <= 1'b0;
      dblimit  <= CNT_W'(DB_RESET);
    end else begin
      if (wr_en_c && address == ADDR_IRQMASK) irq_mask <= writedata[0];
      if (wr_en_c && address == ADDR_DBLIMIT) dblimit  <= writedata[CNT_W-1:0];
      if (edge_c) begin
        edgecap <= 1'b1;
      end else if (wr_en_c && address == ADDR_EDGECAP && writedata[0]) begin
        edgecap <= 1'b0;
      end
    end
  end

  // Registered interrupt and read mux, reloaded every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      irq <= edgecap & irq_mask;
      case (address)
        ADDR_DATA:    readdata <= DATA_W'(level);
        ADDR_IRQMASK: readdata <= DATA_W'(irq_mask);
        ADDR_EDGECAP: readdata <= DATA_W'(edgecap);
        default:      readdata <= DATA_W'(dblimit);
      endcase
    end
  end

endmodule

// File: tb/tb_botao_debounce_ctrl.sv
// Scoreboard bench: press-only and both-edge instances share the bus, separate pins.
module tb_botao_debounce_ctrl;
  import botao_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic        pin;
  logic        pin2;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic        irq;
  logic        irq2;

  logic        chk_req;
  logic        chk_q = 1'b0;
  int          total  = 0;
  int          passed = 0;

  typedef struct {
    string       name;
    bit          sel;
    logic [31:0] rd;
    logic        irq;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  botao_debounce_ctrl #(.DB_RESET(50000), .IDLE_LEVEL(1), .CAPTURE_EDGE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pin),
    .readdata(readdata), .irq(irq)
  );

  botao_debounce_ctrl #(.DB_RESET(50000), .IDLE_LEVEL(1), .CAPTURE_EDGE(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pin2),
    .readdata(readdata2), .irq(irq2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  // Readdata/irq reflect the request registered at the previous posedge.
  always @(posedge clk) chk_q <= chk_req;

  // Monitor: pop one expectation per requested read and compare.
  always @(negedge clk) begin
    if (chk_q) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: got read with empty queue (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, e.sel ? readdata2 : readdata, e.rd);
        check({e.name, "_irq"}, {31'b0, e.sel ? irq2 : irq}, {31'b0, e.irq});
      end
    end
  end

  task automatic idle(input int n);
    chipselect = 1'b0; write_n = 1'b1; chk_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d; chk_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic ei,
                    input string nm, input bit sel = 1'b0);
    exp_t x;
    chipselect = 1'b0; write_n = 1'b1; address = a; writedata = '0; chk_req = 1'b1;
    x.name = nm; x.sel = sel; x.rd = e; x.irq = ei;
    sb.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; pin = 1'b1; pin2 = 1'b1;
    address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; chk_req = 1'b0;
    #2;
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset values
    rd(ADDR_DATA,    32'd1,     1'b0, "rst_data");
    rd(ADDR_EDGECAP, 32'd0,     1'b0, "rst_edgecap");
    rd(ADDR_DBLIMIT, 32'd50000, 1'b0, "rst_dblimit");
    rd(ADDR_IRQMASK, 32'd0,     1'b0, "rst_irqmask");

    // Clean press with limit 4: flip 6 cycles after pin change
    wr(ADDR_DBLIMIT, 32'd4);
    wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
    wr(ADDR_DATA, 32'd0);
    rd(ADDR_DBLIMIT, 32'd4, 1'b0, "dblimit_wr");
    rd(ADDR_IRQMASK, 32'd1, 1'b0, "irqmask_wr");
    pin = 1'b0;
    for (int i = 0; i < 7; i++) rd(ADDR_DATA, 32'd1, 1'b0, "press_hold");
    rd(ADDR_DATA,    32'd0, 1'b0, "press_flip");
    rd(ADDR_EDGECAP, 32'd1, 1'b1, "press_cap_irq");
    pin = 1'b1;
    idle(8);
    rd(ADDR_DATA,    32'd1, 1'b1, "release_level");
    rd(ADDR_EDGECAP, 32'd1, 1'b1, "release_keeps_cap");
    wr(ADDR_EDGECAP, 32'd1);
    rd(ADDR_EDGECAP, 32'd0, 1'b0, "w1c_first");

    // Bounce: 3 low cycles with limit 4 never flips
    pin = 1'b0;
    idle(3);
    pin = 1'b1;
    idle(8);
    rd(ADDR_DATA,    32'd1, 1'b0, "bounce_data");
    rd(ADDR_EDGECAP, 32'd0, 1'b0, "bounce_cap");

    // Set wins over a simultaneous clear
    pin = 1'b0; idle(10); pin = 1'b1; idle(10);
    rd(ADDR_EDGECAP, 32'd1, 1'b1, "cap_pre");
    wr(ADDR_EDGECAP, 32'd0);
    rd(ADDR_EDGECAP, 32'd1, 1'b1, "w0_no_clear");
    pin = 1'b0;
    idle(7);
    wr(ADDR_EDGECAP, 32'd1);
    rd(ADDR_EDGECAP, 32'd1, 1'b1, "set_wins");
    pin = 1'b1;
    idle(8);
    wr(ADDR_EDGECAP, 32'd1);
    rd(ADDR_EDGECAP, 32'd0, 1'b0, "w1c_clear");

    // Both-edge instance, limit 0 acts as 1: flip 3 cycles after pin change
    wr(ADDR_DBLIMIT, 32'd0);
    rd(ADDR_DBLIMIT, 32'd0, 1'b0, "dblimit_zero");
    pin2 = 1'b0;
    for (int i = 0; i < 4; i++) rd(ADDR_DATA, 32'd1, 1'b0, "both_press_hold", 1'b1);
    rd(ADDR_DATA,    32'd0, 1'b0, "both_press_flip", 1'b1);
    rd(ADDR_EDGECAP, 32'd1, 1'b1, "both_press_cap", 1'b1);
    wr(ADDR_EDGECAP, 32'd1);
    rd(ADDR_EDGECAP, 32'd0, 1'b0, "both_clr", 1'b1);
    pin2 = 1'b1;
    for (int i = 0; i < 4; i++) rd(ADDR_DATA, 32'd0, 1'b0, "both_rel_hold", 1'b1);
    rd(ADDR_DATA,    32'd1, 1'b0, "both_rel_flip", 1'b1);
    rd(ADDR_EDGECAP, 32'd1, 1'b1, "both_rel_cap", 1'b1);

    // Reset while waiting with counter at 3
    wr(ADDR_DBLIMIT, 32'd8);
    pin = 1'b0;
    for (int i = 0; i < 6; i++) rd(ADDR_DATA, 32'd1, 1'b0, "wait_pre_rst");
    chk_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_readdata",  readdata,  32'd0);
    check("midrst_readdata2", readdata2, 32'd0);
    check("midrst_irq2", {31'b0, irq2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wr(ADDR_DBLIMIT, 32'd8);
    rd(ADDR_EDGECAP, 32'd0, 1'b0, "no_edge_on_release");
    for (int i = 0; i < 9; i++) rd(ADDR_DATA, 32'd1, 1'b0, "rst_full_interval");
    rd(ADDR_DATA,    32'd0, 1'b0, "rst_reflip");
    rd(ADDR_EDGECAP, 32'd1, 1'b0, "rst_cap");

    idle(3);
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
